// File: rtl/pifo_pop_collector.sv
// Collects level-0 pop results from LEVEL RPU lanes into per-lane 2-entry staging
// buffers and merges them round-robin into a single output FIFO.
module pifo_pop_collector #(
    parameter int unsigned PTW       = 16,
    parameter int unsigned MTW       = 0,
    parameter int unsigned LEVEL     = 4,
    parameter int unsigned TREE_NUM  = 4,
    parameter int unsigned OUT_DEPTH = 8,
    localparam int unsigned TREE_NUM_BITS = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
    localparam int unsigned DW            = MTW + PTW,
    localparam int unsigned LW            = (LEVEL > 1) ? $clog2(LEVEL) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [LEVEL-1:0]                 i_pop_valid,
    input  logic [LEVEL*TREE_NUM_BITS-1:0]   i_tree_id,
    input  logic [LEVEL*DW-1:0]              i_pop_data,
    output logic [LEVEL-1:0]                 o_lane_full,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [TREE_NUM_BITS-1:0]         o_tree_id,
    output logic [DW-1:0]                    o_data,
    output logic [LW-1:0]                    o_lane,
    output logic [15:0]                      o_empty_pop_cnt,
    output logic [LEVEL-1:0]                 o_overflow
);

    localparam int unsigned EW = TREE_NUM_BITS + DW;
    localparam int unsigned OW = EW + LW;
    localparam int unsigned PW = $clog2(OUT_DEPTH);
    localparam int unsigned CW = PW + 1;

    // Lane staging state: entry 0 is the lane head.
    logic [EW-1:0]      stg_q     [LEVEL][2];
    logic [EW-1:0]      stg_d     [LEVEL][2];
    logic [1:0]         stg_cnt_q [LEVEL];
    logic [1:0]         stg_cnt_d [LEVEL];

    // Output FIFO state; entries carry {tree_id, data, lane}.
    logic [OW-1:0]      mem_q [OUT_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      out_cnt_q, out_cnt_d;
    logic [OW-1:0]      head_q, head_d;
    logic               valid_q, valid_d;

    logic [LW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [LEVEL-1:0]   full_q, full_d;
    logic [LEVEL-1:0]   ovf_q, ovf_d;
    logic [15:0]        ecnt_q, ecnt_d;
    logic [16:0]        ecnt_sum;

    logic               gnt_found;
    logic [LW-1:0]      gnt_idx;
    logic [LW-1:0]      scan_idx;
    logic               out_pop;
    logic               xfer;
    logic [OW-1:0]      xfer_ent;

    logic [LEVEL-1:0]   lane_pop;
    logic [LEVEL-1:0]   lane_empty;
    logic [LEVEL-1:0]   lane_accept;
    logic [LEVEL-1:0]   lane_drop;
    logic [EW-1:0]      lane_ent [LEVEL];

    // Round-robin search for the first non-empty lane at or after rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < int'(LEVEL); k++) begin
            if ((32'(rr_ptr_q) + 32'(k)) >= 32'(LEVEL)) begin
                scan_idx = LW'(32'(rr_ptr_q) + 32'(k) - 32'(LEVEL));
            end else begin
                scan_idx = LW'(32'(rr_ptr_q) + 32'(k));
            end
            if (!gnt_found && (stg_cnt_q[scan_idx] != 2'd0)) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign out_pop  = valid_q && i_ready;
    assign xfer     = gnt_found && ((out_cnt_q < CW'(OUT_DEPTH)) || out_pop);
    assign xfer_ent = {stg_q[gnt_idx][0], gnt_idx};

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (gnt_idx == LW'(LEVEL - 1)) ? '0 : gnt_idx + LW'(1);
        end
    end

    // Per-lane input classification: empty pop, accepted, or dropped.
    always_comb begin
        lane_pop    = '0;
        lane_empty  = '0;
        lane_accept = '0;
        lane_drop   = '0;
        for (int i = 0; i < int'(LEVEL); i++) begin
            lane_ent[i]    = {i_tree_id[i*TREE_NUM_BITS +: TREE_NUM_BITS], i_pop_data[i*DW +: DW]};
            lane_pop[i]    = xfer && (gnt_idx == LW'(i));
            lane_empty[i]  = i_pop_valid[i] && (&i_pop_data[i*DW +: DW]);
            lane_accept[i] = i_pop_valid[i] && !(&i_pop_data[i*DW +: DW])
                             && ((stg_cnt_q[i] != 2'd2) || lane_pop[i]);
            lane_drop[i]   = i_pop_valid[i] && !(&i_pop_data[i*DW +: DW]) && !lane_accept[i];
        end
    end

    // Staging next state: dequeue shifts entry 1 down, enqueue lands behind survivors.
    always_comb begin
        full_d = '0;
        for (int i = 0; i < int'(LEVEL); i++) begin
            stg_d[i][0]  = stg_q[i][0];
            stg_d[i][1]  = stg_q[i][1];
            stg_cnt_d[i] = stg_cnt_q[i];
            if (lane_pop[i]) begin
                stg_d[i][0]  = stg_q[i][1];
                stg_cnt_d[i] = stg_cnt_q[i] - 2'd1;
            end
            if (lane_accept[i]) begin
                stg_d[i][stg_cnt_d[i][0]] = lane_ent[i];
                stg_cnt_d[i]              = stg_cnt_d[i] + 2'd1;
            end
            full_d[i] = (stg_cnt_d[i] == 2'd2);
        end
    end

    always_comb begin
        ovf_d    = ovf_q | lane_drop;
        ecnt_sum = {1'b0, ecnt_q};
        for (int i = 0; i < int'(LEVEL); i++) begin
            if (lane_empty[i]) begin
                ecnt_sum = ecnt_sum + 17'd1;
            end
        end
        ecnt_d = ecnt_sum[16] ? 16'hFFFF : ecnt_sum[15:0];
    end

    // Output FIFO bookkeeping; the head register is bypassed when the write lands at the new head.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(xfer);
        rd_ptr_d  = rd_ptr_q + PW'(out_pop);
        out_cnt_d = out_cnt_q + CW'(xfer) - CW'(out_pop);
        valid_d   = (out_cnt_d != '0);
        head_d    = head_q;
        if (xfer && (wr_ptr_q == rd_ptr_d)) begin
            head_d = xfer_ent;
        end else if (out_cnt_d != '0) begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(LEVEL); i++) begin
                stg_q[i][0]  <= '0;
                stg_q[i][1]  <= '0;
                stg_cnt_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_cnt_q <= '0;
            head_q    <= '0;
            valid_q   <= 1'b0;
            rr_ptr_q  <= '0;
            full_q    <= '0;
            ovf_q     <= '0;
            ecnt_q    <= '0;
        end else begin
            for (int i = 0; i < int'(LEVEL); i++) begin
                stg_q[i][0]  <= stg_d[i][0];
                stg_q[i][1]  <= stg_d[i][1];
                stg_cnt_q[i] <= stg_cnt_d[i];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            out_cnt_q <= out_cnt_d;
            head_q    <= head_d;
            valid_q   <= valid_d;
            rr_ptr_q  <= rr_ptr_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            ecnt_q    <= ecnt_d;
        end
    end

    // FIFO storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge i_clk) begin
        if (!i_rst && xfer) begin
            mem_q[wr_ptr_q] <= xfer_ent;
        end
    end

    assign o_valid         = valid_q;
    assign o_lane          = head_q[LW-1:0];
    assign o_data          = head_q[LW +: DW];
    assign o_tree_id       = head_q[LW+DW +: TREE_NUM_BITS];
    assign o_lane_full     = full_q;
    assign o_overflow      = ovf_q;
    assign o_empty_pop_cnt = ecnt_q;

endmodule

// File: tb/tb_pifo_pop_collector.sv
// Bench for pifo_pop_collector: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pifo_pop_collector;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [1:0]  tid;
        logic [15:0] data;
        logic [1:0]  lane;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [3:0]  pv;
    logic [7:0]  tid;
    logic [63:0] pd;
    logic [3:0]  lane_full;
    logic [3:0]  ovf;
    logic        valid;
    logic [1:0]  o_tid;
    logic [1:0]  o_lane;
    logic [15:0] o_data;
    logic [15:0] ecnt;

    always #5 clk = ~clk;

    pifo_pop_collector dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pop_valid    (pv),
        .i_tree_id      (tid),
        .i_pop_data     (pd),
        .o_lane_full    (lane_full),
        .o_valid        (valid),
        .i_ready        (rdy),
        .o_tree_id      (o_tid),
        .o_data         (o_data),
        .o_lane         (o_lane),
        .o_empty_pop_cnt(ecnt),
        .o_overflow     (ovf)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-lane queues feeding one output queue.
    ent_t       lane_q [4][$];
    ent_t       out_q  [$];
    int         m_rr   = 0;
    logic [3:0] m_ovf  = '0;
    int         m_ecnt = 0;
    bit         m_init = 1'b0;
    bit         mp, mx, mf;
    int         mg;
    bit         acc [4];
    ent_t       me;
    logic [63:0] rnd_data;

    task automatic model_step();
        if (rst) begin
            for (int l = 0; l < 4; l++) lane_q[l].delete();
            out_q.delete();
            m_rr   = 0;
            m_ovf  = '0;
            m_ecnt = 0;
            m_init = 1'b1;
        end else begin
            mp = (out_q.size() != 0) && (rdy === 1'b1);
            mf = 1'b0;
            mg = 0;
            for (int k = 0; k < 4; k++) begin
                if (!mf && lane_q[(m_rr + k) % 4].size() != 0) begin
                    mf = 1'b1;
                    mg = (m_rr + k) % 4;
                end
            end
            mx = mf && ((out_q.size() < DEPTH) || mp);
            for (int l = 0; l < 4; l++) acc[l] = (lane_q[l].size() < 2) || (mx && mg == l);
            if (mp) void'(out_q.pop_front());
            if (mx) begin
                me      = lane_q[mg].pop_front();
                me.lane = 2'(mg);
                out_q.push_back(me);
                m_rr    = (mg + 1) % 4;
            end
            for (int l = 0; l < 4; l++) begin
                if (pv[l]) begin
                    if (pd[l*16 +: 16] == 16'hFFFF) begin
                        if (m_ecnt < 65535) m_ecnt++;
                    end else if (acc[l]) begin
                        me.tid  = tid[l*2 +: 2];
                        me.data = pd[l*16 +: 16];
                        me.lane = 2'(l);
                        lane_q[l].push_back(me);
                    end else begin
                        m_ovf[l] = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_full();
        logic [3:0] r;
        for (int l = 0; l < 4; l++) r[l] = (lane_q[l].size() == 2);
        return r;
    endfunction

    // One clock edge with the given inputs; returns 1 time unit after the edge.
    task automatic drive(input logic r, input logic [3:0] v, input logic [7:0] t,
                         input logic [63:0] d, input logic rd);
        rst = r;
        pv  = v;
        tid = t;
        pd  = d;
        rdy = rd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("m_valid", 32'(valid), 32'(out_q.size() != 0));
                if (out_q.size() != 0) begin
                    chk("m_tid",  32'(o_tid),  32'(out_q[0].tid));
                    chk("m_data", 32'(o_data), 32'(out_q[0].data));
                    chk("m_lane", 32'(o_lane), 32'(out_q[0].lane));
                end
                chk("m_full", 32'(lane_full), 32'(exp_full()));
                chk("m_ovf",  32'(ovf),       32'(m_ovf));
                chk("m_ecnt", 32'(ecnt),      32'(m_ecnt));
            end
        end
    end

    initial begin
        rst = 1'b1; pv = '0; tid = '0; pd = '0; rdy = 1'b1;
        drive(1, 4'h0, 8'h00, 64'h0, 1);
        drive(1, 4'h0, 8'h00, 64'h0, 1);
        chk("rst_valid", 32'(valid),     32'd0);
        chk("rst_ecnt",  32'(ecnt),      32'd0);
        chk("rst_ovf",   32'(ovf),       32'd0);
        chk("rst_full",  32'(lane_full), 32'd0);
        chk("rst_data",  32'(o_data),    32'd0);

        // single result on lane 2, tree 3
        drive(0, 4'b0100, 8'h30, 64'h0000_0005_0000_0000, 1);
        chk("lat_early", 32'(valid), 32'd0);
        drive(0, 4'h0, 8'h00, 64'h0, 1);
        chk("lat_valid", 32'(valid),  32'd1);
        chk("lat_tid",   32'(o_tid),  32'd3);
        chk("lat_data",  32'(o_data), 32'h5);
        chk("lat_lane",  32'(o_lane), 32'd2);
        drive(0, 4'h0, 8'h00, 64'h0, 1);
        chk("lat_drain", 32'(valid), 32'd0);

        // all lanes at once from rr_ptr 0
        drive(1, 4'h0, 8'h00, 64'h0, 1);
        drive(0, 4'hF, 8'hE4, 64'h0004_0003_0002_0001, 1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 4'h0, 8'h00, 64'h0, 1);
            chk("rr_valid", 32'(valid),  32'd1);
            chk("rr_lane",  32'(o_lane), 32'(k));
            chk("rr_tid",   32'(o_tid),  32'(k));
            chk("rr_data",  32'(o_data), 32'(k + 1));
        end
        drive(0, 4'h0, 8'h00, 64'h0, 1);
        chk("rr_done", 32'(valid), 32'd0);

        // empty pop filtered
        drive(0, 4'b0001, 8'h00, 64'h0000_0000_0000_FFFF, 1);
        chk("emp_cnt",  32'(ecnt),      32'd1);
        chk("emp_full", 32'(lane_full), 32'd0);
        drive(0, 4'h0, 8'h00, 64'h0, 1);
        chk("emp_valid", 32'(valid), 32'd0);

        // backpressure: lane 1 for 11 cycles with consumer stalled
        for (int k = 0; k < 11; k++)
            drive(0, 4'b0010, 8'h04, {32'h0, 16'(16'h100 + k), 16'h0}, 0);
        chk("bp_valid", 32'(valid),     32'd1);
        chk("bp_data",  32'(o_data),    32'h100);
        chk("bp_lane",  32'(o_lane),    32'd1);
        chk("bp_tid",   32'(o_tid),     32'd1);
        chk("bp_full",  32'(lane_full), 32'h2);
        chk("bp_ovf",   32'(ovf),       32'h2);
        for (int k = 0; k < 12; k++) drive(0, 4'h0, 8'h00, 64'h0, 1);
        chk("bp_drained", 32'(valid), 32'd0);
        chk("bp_sticky",  32'(ovf),   32'h2);

        // reset with 5 entries queued and inputs active during reset
        for (int k = 0; k < 6; k++)
            drive(0, 4'b1000, 8'hC0, {16'(16'h200 + k), 48'h0}, 0);
        chk("q5_valid", 32'(valid), 32'd1);
        drive(1, 4'hF, 8'hFF, 64'h0007_0007_0007_FFFF, 1);
        chk("rq_valid", 32'(valid),     32'd0);
        chk("rq_full",  32'(lane_full), 32'd0);
        chk("rq_ovf",   32'(ovf),       32'd0);
        chk("rq_ecnt",  32'(ecnt),      32'd0);
        drive(0, 4'h0, 8'h00, 64'h0, 1);
        chk("rq_ignored", 32'(valid), 32'd0);

        // empty-pop counter saturation
        for (int k = 0; k < 16400; k++) drive(0, 4'hF, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("sat_cnt",   32'(ecnt),  32'hFFFF);
        chk("sat_valid", 32'(valid), 32'd0);

        // mixed traffic with intermittent stalls
        drive(1, 4'h0, 8'h00, 64'h0, 1);
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < 4; l++)
                rnd_data[l*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                                       : 16'($urandom_range(0, 65534));
            drive(0, 4'($urandom), 8'($urandom), rnd_data, ($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 30; k++) drive(0, 4'h0, 8'h00, 64'h0, 1);
        chk("mix_drained", 32'(valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
